// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control unit: sequences fetch, decode, execute, memory and
// writeback steps and drives the datapath enables and mux selects.
module mc_control_fsm #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int EN_ITYPE      = 1,
  parameter int EN_JAL        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t cur, nxt;
  logic   rdy;
  logic   mem_req_c, pc_write_c, ir_write_c, reg_write_c, mem_write_c, illegal_c;

  assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_FETCH;
    else        cur <= nxt;
  end

  always_comb begin
    nxt         = S_FETCH;
    mem_req_c   = 1'b0;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;
    illegal_c   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_op      = 2'b00;
    case (cur)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_c = rdy;
        pc_write_c = rdy;
        nxt        = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECR;
          OP_I:         nxt = (EN_ITYPE != 0) ? S_EXECI : S_TRAP;
          OP_BEQ:       nxt = S_BEQ;
          OP_JAL:       nxt = (EN_JAL != 0) ? S_JAL : S_TRAP;
          default:      nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        nxt       = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
        nxt       = rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
      end
      // mem_write stays asserted for the whole stall so the memory sees a stable request
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src     = 1'b1;
        nxt         = rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        nxt       = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        nxt       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write_c = zero;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_c = 1'b1;
        nxt        = S_ALUWB;
      end
      S_TRAP: begin
        illegal_c = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Reset gates the write enables directly so nothing commits while rst_n is low
  assign mem_req   = mem_req_c   & rst_n;
  assign pc_write  = pc_write_c  & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign reg_write = reg_write_c & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign illegal   = illegal_c   & rst_n;
  assign state     = cur;

endmodule
